pmem_responder: RTL

- Line-granular physical-memory responder for the pmem bus. It is the far end of the pmem_read/pmem_write/pmem_resp handshake that the L2 cache control drives.
- Holds a line-addressed storage array and services one read or write at a time.
- Returns a single-cycle pmem_resp a fixed, parameterised number of cycles after accepting a request.
- Used as the synthesizable main-memory stand-in below L2 and as the bus model in L2 benches.

---
 rtl/pmem_responder_pkg.sv | 19 +
 rtl/pmem_responder_if.sv | 36 +++
 rtl/pmem_responder_array.sv | 37 +++
 rtl/pmem_responder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem line responder.
// Line geometry, FSM states and request opcodes.
package pmem_types;

   localparam int PMEM_LINE_WIDTH = 256;
   localparam int PMEM_OFS_BITS   = $clog2(PMEM_LINE_WIDTH / 8);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } pmem_state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } pmem_op_t;

endpackage

// File: rtl/pmem_responder_if.sv
// pmem bus between an L2 controller (master) and memory (slave).
// Level-held read/write request, one-cycle resp pulse.
interface pmem_if #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
);

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;
   logic                  proto_err;

   modport master (
      output pmem_read,
      output pmem_write,
      output pmem_address,
      output pmem_wdata,
      input  pmem_rdata,
      input  pmem_resp,
      input  proto_err
   );

   modport slave (
      input  pmem_read,
      input  pmem_write,
      input  pmem_address,
      input  pmem_wdata,
      output pmem_rdata,
      output pmem_resp,
      output proto_err
   );

endinterface

// File: rtl/pmem_responder_array.sv
// Single-port line storage, synchronous write and registered read.
// The read register only loads on re, so it holds the last read line.
module pmem_line_array #(
   parameter int LINE_WIDTH = 256,
   parameter int INDEX_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [INDEX_BITS-1:0] addr,
   input  logic [LINE_WIDTH-1:0] wdata,
   output logic [LINE_WIDTH-1:0] rdata
);

   logic [LINE_WIDTH-1:0] mem_q [2**INDEX_BITS];
   logic [LINE_WIDTH-1:0] rdata_q;
   logic [LINE_WIDTH-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[addr];
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency pmem responder: accepts one line read/write,
// commits on the edge entering RESP, pulses pmem_resp once.
module pmem_responder
   import pmem_types::*;
#(
   parameter int LINE_WIDTH = PMEM_LINE_WIDTH,
   parameter int ADDR_WIDTH = 32,
   parameter int INDEX_BITS = 8,
   parameter int LATENCY    = 4
) (
   input  logic  clk,
   input  logic  rst,
   pmem_if.slave bus
);

   localparam int         OFS    = $clog2(LINE_WIDTH / 8);
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   pmem_state_t           state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   pmem_op_t              op_q, op_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;

   logic                  rd, wr;
   logic [INDEX_BITS-1:0] req_idx;
   logic                  arr_we, arr_re;
   logic [INDEX_BITS-1:0] arr_addr;
   logic [LINE_WIDTH-1:0] arr_wdata;
   logic [LINE_WIDTH-1:0] arr_rdata;
   logic                  unused_addr;

   assign rd      = bus.pmem_read;
   assign wr      = bus.pmem_write;
   assign req_idx = bus.pmem_address[OFS+INDEX_BITS-1:OFS];

   assign unused_addr = ^{bus.pmem_address[ADDR_WIDTH-1:OFS+INDEX_BITS],
                          bus.pmem_address[OFS-1:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = idx_q;
      arr_wdata = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (rd && wr) begin
               err_d = 1'b1;
            end else if (rd || wr) begin
               op_d    = wr ? OP_WRITE : OP_READ;
               idx_d   = req_idx;
               wdata_d = bus.pmem_wdata;
               cnt_d   = LAT_M1;
               if (LATENCY == 1) begin
                  // No BUSY phase: commit straight from the bus.
                  state_d   = RESP;
                  arr_addr  = req_idx;
                  arr_wdata = bus.pmem_wdata;
                  arr_we    = wr;
                  arr_re    = rd;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (rd != (op_q == OP_READ) || wr != (op_q == OP_WRITE))
               err_d = 1'b1;
            if (cnt_q == 8'd1) begin
               state_d = RESP;
               arr_we  = (op_q == OP_WRITE);
               arr_re  = (op_q == OP_READ);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   // A reset in the commit cycle aborts the write.
   pmem_line_array #(
      .LINE_WIDTH (LINE_WIDTH),
      .INDEX_BITS (INDEX_BITS)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (arr_we & ~rst),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   assign bus.pmem_resp  = (state_q == RESP);
   assign bus.pmem_rdata = arr_rdata;
   assign bus.proto_err  = err_q;

endmodule
